// File: rtl/n1_ir_pkg.sv
// rtl/n1_ir_pkg.sv - N1 instruction register package: widths, field positions, forced words, decode struct
package N1_ir_pkg;

  localparam int IW    = 16;
  localparam int ADR_W = 14;
  localparam int OPC_W = 11;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 14;
  localparam int EOW_BIT = 13;
  localparam int CLS_MSB = 12;
  localparam int CLS_LSB = 11;
  localparam int RD_BIT  = 10;

  localparam logic [IW-1:0] IR_NOP      = 16'h0000;
  localparam logic [IW-1:0] IR_DROP     = 16'h0001;
  localparam logic [IW-1:0] IR_CALL_IND = 16'h0002;
  localparam logic [IW-1:0] IR_0CALL    = 16'h8000;

  // Stack/ALU opcode that turns a linear word into an indirect call through PS0
  localparam logic [OPC_W-1:0] CALL_IND_OPC = 11'h002;

  typedef enum logic [1:0] {
    OP_LIN  = 2'b00,
    OP_BRA  = 2'b01,
    OP_CALL = 2'b10,
    OP_JUMP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'b00,
    CLS_LIT     = 2'b01,
    CLS_MEM_DIR = 2'b10,
    CLS_MEM_IND = 2'b11
  } cls_t;

  typedef struct packed {
    logic eow;
    logic eow_postpone;
    logic jump_or_call;
    logic bra;
    logic scyc;
    logic mem;
    logic mem_rd;
    logic madr_sel;
  } ir_dec_t;

endpackage

// File: rtl/n1_ir_dec.sv
// rtl/n1_ir_dec.sv - combinational decoder of one instruction word into flow-control flags
import N1_ir_pkg::*;

module N1_ir_dec (
  input  logic [IW-1:0]    ir_i,
  output ir_dec_t          dec_o,
  output logic [ADR_W-1:0] abs_adr_o,
  output logic [OPC_W-1:0] opc_o
);

  op_t  op;
  cls_t cls;
  logic is_lin;
  logic is_call_ind;
  logic is_mem;

  assign op        = op_t'(ir_i[OP_MSB:OP_LSB]);
  assign cls       = cls_t'(ir_i[CLS_MSB:CLS_LSB]);
  assign abs_adr_o = ir_i[ADR_W-1:0];
  assign opc_o     = ir_i[OPC_W-1:0];

  always_comb begin
    dec_o       = '0;
    is_lin      = (op == OP_LIN);
    // The EOW bit is not part of the opcode, so a forced EOW keeps CALL_IND recognised
    is_call_ind = is_lin && (cls == CLS_ALU) && (ir_i[OPC_W-1:0] == CALL_IND_OPC);
    is_mem      = is_lin && ((cls == CLS_MEM_DIR) || (cls == CLS_MEM_IND));

    dec_o.eow          = (is_lin && ir_i[EOW_BIT]) || (op == OP_JUMP);
    dec_o.mem          = is_mem;
    dec_o.mem_rd       = is_mem && ir_i[RD_BIT];
    dec_o.madr_sel     = is_lin && (cls == CLS_MEM_DIR);
    dec_o.eow_postpone = dec_o.eow && is_mem;
    dec_o.jump_or_call = (op == OP_JUMP) || (op == OP_CALL) || is_call_ind;
    dec_o.bra          = (op == OP_BRA);
    dec_o.scyc         = is_lin && ((cls == CLS_ALU) || (cls == CLS_LIT)) && !is_call_ind;
  end

endmodule

// File: rtl/n1_ir.sv
// rtl/n1_ir.sv - N1 instruction register: current/stash words, command priority mux, decode
// Probe ports prb_ir_* exist only when N1_IR_PRB_EN is defined.
import N1_ir_pkg::*;

module n1_ir (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  input  logic [IW-1:0]    pbus_dat_i,
  input  logic             fc2ir_capture_i,
  input  logic             fc2ir_stash_i,
  input  logic             fc2ir_expend_i,
  input  logic             fc2ir_force_eow_i,
  input  logic             fc2ir_force_0call_i,
  input  logic             fc2ir_force_call_i,
  input  logic             fc2ir_force_drop_i,
  input  logic             fc2ir_force_nop_i,
  output logic             ir2fc_eow_o,
  output logic             ir2fc_eow_postpone_o,
  output logic             ir2fc_jump_or_call_o,
  output logic             ir2fc_bra_o,
  output logic             ir2fc_scyc_o,
  output logic             ir2fc_mem_o,
  output logic             ir2fc_mem_rd_o,
  output logic             ir2fc_madr_sel_o,
  output logic [ADR_W-1:0] ir2dsp_abs_adr_o,
  output logic [OPC_W-1:0] ir2prs_opc_o
`ifdef N1_IR_PRB_EN
  ,
  output logic [IW-1:0]    prb_ir_cur_o,
  output logic [IW-1:0]    prb_ir_stash_o,
  output logic             prb_ir_stash_vld_o
`endif
);

  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] stash_q, stash_d;
  logic          stash_vld_q, stash_vld_d;
  logic [IW-1:0] sel;
  ir_dec_t       dec;

  always_comb begin
    stash_d     = stash_q;
    stash_vld_d = stash_vld_q;
    sel         = cur_q;

    // A simultaneous stash wins over expend so the new word stays valid
    if (fc2ir_stash_i) begin
      stash_d     = pbus_dat_i;
      stash_vld_d = 1'b1;
    end else if (fc2ir_expend_i) begin
      stash_vld_d = 1'b0;
    end

    if (fc2ir_force_0call_i)      sel = IR_0CALL;
    else if (fc2ir_force_call_i)  sel = IR_CALL_IND;
    else if (fc2ir_force_drop_i)  sel = IR_DROP;
    else if (fc2ir_force_nop_i)   sel = IR_NOP;
    else if (fc2ir_expend_i)      sel = stash_vld_q ? stash_q : IR_NOP;
    else if (fc2ir_capture_i)     sel = pbus_dat_i;

    if (fc2ir_force_eow_i && (sel[OP_MSB:OP_LSB] == OP_LIN)) sel[EOW_BIT] = 1'b1;

    cur_d = sel;
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      cur_q       <= IR_NOP;
      stash_q     <= IR_NOP;
      stash_vld_q <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      stash_q     <= stash_d;
      stash_vld_q <= stash_vld_d;
    end
  end

  N1_ir_dec u_dec (
    .ir_i      (cur_q),
    .dec_o     (dec),
    .abs_adr_o (ir2dsp_abs_adr_o),
    .opc_o     (ir2prs_opc_o)
  );

  assign ir2fc_eow_o          = dec.eow;
  assign ir2fc_eow_postpone_o = dec.eow_postpone;
  assign ir2fc_jump_or_call_o = dec.jump_or_call;
  assign ir2fc_bra_o          = dec.bra;
  assign ir2fc_scyc_o         = dec.scyc;
  assign ir2fc_mem_o          = dec.mem;
  assign ir2fc_mem_rd_o       = dec.mem_rd;
  assign ir2fc_madr_sel_o     = dec.madr_sel;

`ifdef N1_IR_PRB_EN
  assign prb_ir_cur_o       = cur_q;
  assign prb_ir_stash_o     = stash_q;
  assign prb_ir_stash_vld_o = stash_vld_q;
`endif

endmodule

// File: tb/tb_n1_ir.sv
// tb/tb_n1_ir.sv - self-checking bench for n1_ir against a word-level reference model
module tb_n1_ir;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dat;
  logic        cap, stash, expend, feow, f0call, fcall, fdrop, fnop;

  logic        eow, eow_pp, joc, bra, scyc, mem, mem_rd, madr;
  logic [13:0] abs_adr;
  logic [10:0] opc;
`ifdef N1_IR_PRB_EN
  logic [15:0] prb_cur, prb_stash;
  logic        prb_vld;
`endif

  always #5 clk = ~clk;

  n1_ir dut (
    .clk_i                (clk),
    .sync_rst_i           (rst_n),
    .pbus_dat_i           (dat),
    .fc2ir_capture_i      (cap),
    .fc2ir_stash_i        (stash),
    .fc2ir_expend_i       (expend),
    .fc2ir_force_eow_i    (feow),
    .fc2ir_force_0call_i  (f0call),
    .fc2ir_force_call_i   (fcall),
    .fc2ir_force_drop_i   (fdrop),
    .fc2ir_force_nop_i    (fnop),
    .ir2fc_eow_o          (eow),
    .ir2fc_eow_postpone_o (eow_pp),
    .ir2fc_jump_or_call_o (joc),
    .ir2fc_bra_o          (bra),
    .ir2fc_scyc_o         (scyc),
    .ir2fc_mem_o          (mem),
    .ir2fc_mem_rd_o       (mem_rd),
    .ir2fc_madr_sel_o     (madr),
    .ir2dsp_abs_adr_o     (abs_adr),
    .ir2prs_opc_o         (opc)
`ifdef N1_IR_PRB_EN
    ,
    .prb_ir_cur_o         (prb_cur),
    .prb_ir_stash_o       (prb_stash),
    .prb_ir_stash_vld_o   (prb_vld)
`endif
  );

  wire [32:0] obs = {eow, eow_pp, joc, bra, scyc, mem, mem_rd, madr, abs_adr, opc};

  int vectors = 0;
  int errors  = 0;

  logic [15:0] m_cur, m_stash;
  logic        m_vld;

  // Expected output bundle of a word, read straight from the instruction encoding
  function automatic logic [32:0] exp_out(input logic [15:0] w);
    logic [1:0] op, cls;
    logic lin, jmp, call, brn, cind, is_mem, e;
    op     = w[15:14];
    cls    = w[12:11];
    lin    = (op == 2'b00);
    jmp    = (op == 2'b11);
    call   = (op == 2'b10);
    brn    = (op == 2'b01);
    cind   = lin && (cls == 2'b00) && (w[10:0] == 11'd2);
    is_mem = lin && (cls >= 2'b10);
    e      = (lin && w[13]) || jmp;
    return {e, e && is_mem, jmp || call || cind, brn,
            lin && (cls <= 2'b01) && !cind, is_mem, is_mem && w[10],
            lin && (cls == 2'b10), w[13:0], w[10:0]};
  endfunction

  task automatic idle();
    cap = 0; stash = 0; expend = 0; feow = 0;
    f0call = 0; fcall = 0; fdrop = 0; fnop = 0;
  endtask

  // Apply the current inputs for one clock and advance the model
  task automatic cycle();
    logic [15:0] nxt;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_cur = 16'h0000; m_stash = 16'h0000; m_vld = 1'b0;
    end else begin
      nxt = m_cur;
      if (f0call)      nxt = 16'h8000;
      else if (fcall)  nxt = 16'h0002;
      else if (fdrop)  nxt = 16'h0001;
      else if (fnop)   nxt = 16'h0000;
      else if (expend) nxt = m_vld ? m_stash : 16'h0000;
      else if (cap)    nxt = dat;
      if (feow && nxt[15:14] == 2'b00) nxt = nxt | 16'h2000;
      if (stash) begin
        m_stash = dat; m_vld = 1'b1;
      end else if (expend) begin
        m_vld = 1'b0;
      end
      m_cur = nxt;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); cap = 1; stash = 1; fcall = 1; dat = 16'hFFFF;
    cycle();
    idle(); rst_n = 1;
    vectors++;
    if (obs !== exp_out(16'h0000)) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, exp_out(16'h0000));
    end
    vectors++;
    if ({eow, joc, mem, scyc} !== 4'b0001) begin
      errors++; $display("FAIL reset_scyc: got eow/joc/mem/scyc=%b want 0001", {eow, joc, mem, scyc});
    end
  endtask

  task automatic test_capture_jump();
    idle(); cap = 1; dat = 16'hC123;
    cycle(); idle();
    vectors++;
    if ({joc, eow, abs_adr} !== {1'b1, 1'b1, 14'h0123}) begin
      errors++; $display("FAIL capture_jump: got joc=%b eow=%b adr=%h want 1 1 0123", joc, eow, abs_adr);
    end
    vectors++;
    if (obs !== exp_out(16'hC123)) begin
      errors++; $display("FAIL capture_jump_all: got %h want %h", obs, exp_out(16'hC123));
    end
  endtask

  task automatic test_stash_expend_mem();
    idle(); stash = 1; dat = 16'h1400;
    cycle();
    idle(); expend = 1; dat = 16'hFFFF;
    cycle(); idle();
    vectors++;
    if ({mem, mem_rd, madr, scyc} !== 4'b1110) begin
      errors++; $display("FAIL expend_mem: got mem/rd/madr/scyc=%b want 1110", {mem, mem_rd, madr, scyc});
    end
    expend = 1;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h0000)) begin
      errors++; $display("FAIL stash_vld_clear: got %h want %h", obs, exp_out(16'h0000));
    end
  endtask

  task automatic test_force_priority();
    idle(); f0call = 1; cap = 1; dat = 16'h4055;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h8000)) begin
      errors++; $display("FAIL force_0call: got %h want %h", obs, exp_out(16'h8000));
    end
    fcall = 1; fdrop = 1; fnop = 1;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h0002) || joc !== 1'b1 || scyc !== 1'b0) begin
      errors++; $display("FAIL force_call: got %h want %h", obs, exp_out(16'h0002));
    end
    fdrop = 1; fnop = 1;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h0001)) begin
      errors++; $display("FAIL force_drop: got %h want %h", obs, exp_out(16'h0001));
    end
  endtask

  task automatic test_force_eow();
    idle(); cap = 1; feow = 1; dat = 16'h3400;
    cycle(); idle();
    vectors++;
    if (eow_pp !== 1'b1 || obs !== exp_out(16'h3400)) begin
      errors++; $display("FAIL eow_postpone: got %h want %h", obs, exp_out(16'h3400));
    end
    cap = 1; feow = 1; dat = 16'h0005;
    cycle(); idle();
    vectors++;
    if (eow !== 1'b1 || obs !== exp_out(16'h2005)) begin
      errors++; $display("FAIL force_eow_lin: got %h want %h", obs, exp_out(16'h2005));
    end
    cap = 1; feow = 1; dat = 16'h4011;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h4011) || eow !== 1'b0) begin
      errors++; $display("FAIL force_eow_branch: got %h want %h", obs, exp_out(16'h4011));
    end
  endtask

  task automatic test_back_to_back();
    idle(); expend = 1;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h0000)) begin
      errors++; $display("FAIL expend_empty: got %h want %h", obs, exp_out(16'h0000));
    end
    stash = 1; dat = 16'h8ABC;
    cycle(); idle();
    stash = 1; expend = 1; dat = 16'h4321;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h8ABC)) begin
      errors++; $display("FAIL stash_expend_cur: got %h want %h", obs, exp_out(16'h8ABC));
    end
    expend = 1;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h4321)) begin
      errors++; $display("FAIL stash_expend_new: got %h want %h", obs, exp_out(16'h4321));
    end
  endtask

  task automatic test_reset_mid();
    idle(); stash = 1; dat = 16'hC777;
    cycle(); idle();
    rst_n = 0; fcall = 1;
    cycle(); idle(); rst_n = 1;
    vectors++;
    if (obs !== exp_out(16'h0000)) begin
      errors++; $display("FAIL reset_mid_cur: got %h want %h", obs, exp_out(16'h0000));
    end
    expend = 1;
    cycle(); idle();
    vectors++;
    if (obs !== exp_out(16'h0000)) begin
      errors++; $display("FAIL reset_mid_stash: got %h want %h", obs, exp_out(16'h0000));
    end
  endtask

  task automatic test_random();
    int f;
    for (int i = 0; i < 400; i++) begin
      idle();
      rst_n  = ($urandom_range(0, 49) != 0);
      dat    = 16'($urandom);
      cap    = 1'($urandom);
      stash  = 1'($urandom);
      feow   = ($urandom_range(0, 3) == 0);
      f      = $urandom_range(0, 9);
      f0call = (f == 0);
      fcall  = (f == 1);
      fdrop  = (f == 2);
      fnop   = (f == 3);
      expend = (f > 3) && 1'($urandom);
      cycle();
      vectors++;
      if (obs !== exp_out(m_cur)) begin
        errors++; $display("FAIL random_%0d: got %h want %h (cur %h)", i, obs, exp_out(m_cur), m_cur);
      end
`ifdef N1_IR_PRB_EN
      vectors++;
      if ({prb_cur, prb_stash, prb_vld} !== {m_cur, m_stash, m_vld}) begin
        errors++; $display("FAIL random_probe_%0d: got %h %h %b want %h %h %b",
                           i, prb_cur, prb_stash, prb_vld, m_cur, m_stash, m_vld);
      end
`endif
    end
    rst_n = 1; idle();
  endtask

  initial begin
    rst_n = 0; dat = 16'h0000; idle();
    m_cur = 16'h0000; m_stash = 16'h0000; m_vld = 1'b0;
    test_reset();
    test_capture_jump();
    test_stash_expend_mem();
    test_force_priority();
    test_force_eow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
